// File: rtl/multicycle_controller.sv
// ----------------------------------------------------------------------------
// multicycle_controller
//
// Main control FSM for a multicycle RV32-style datapath: lw, sw, R-type,
// I-type ALU, beq and jal. Moore machine; the exceptions are that PCWrite in
// BEQ follows the ALU zero flag, and that FETCH/MEMREAD/MEMWRITE stall on
// mem_ready.
//
// Parameters
//   MEM_WAIT_EN : 1 = honour mem_ready, 0 = memory is always ready.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset (forces FETCH)
//   op[6:0]    in   opcode field from the instruction register
//   zero       in   ALU zero flag
//   mem_ready  in   memory access completes this cycle
//   PCWrite    out  PC load enable
//   AdrSrc     out  memory address select (0 = PC, 1 = ALUOut)
//   MemWrite   out  data memory write strobe
//   IRWrite    out  IR / old-PC load enable
//   ResultSrc  out  result select (00 ALUOut, 01 mem data, 10 ALU result)
//   ALUSrcA    out  ALU A select (00 PC, 01 old PC, 10 rs1)
//   ALUSrcB    out  ALU B select (00 rs2, 01 imm, 10 const 4)
//   RegWrite   out  register file write enable
//   ALUOp      out  ALU decoder op (00 add, 01 sub, 10 funct decode)
//   illegal_op out  one-cycle pulse on an unsupported opcode in DECODE
//   state[3:0] out  current state encoding (debug)
// ----------------------------------------------------------------------------
module multicycle_controller #(
    parameter bit MEM_WAIT_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       RegWrite,
    output logic [1:0] ALUOp,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    state_t state_reg;
    state_t state_next;
    logic   ready;

    // With waiting disabled the memory is treated as single-cycle.
    assign ready = MEM_WAIT_EN ? mem_ready : 1'b1;
    assign state = state_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = S_FETCH;
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        RegWrite   = 1'b0;
        ALUOp      = 2'b00;
        illegal_op = 1'b0;

        case (state_reg)
            S_FETCH: begin
                // PC + 4 goes straight from the ALU into the PC.
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                if (ready) begin
                    PCWrite    = 1'b1;
                    IRWrite    = 1'b1;
                    state_next = S_DECODE;
                end else begin
                    state_next = S_FETCH;
                end
            end
            S_DECODE: begin
                // Branch target (old PC + imm) is precomputed into ALUOut.
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_RTYPE:          state_next = S_EXECR;
                    OP_ITYPE:          state_next = S_EXECI;
                    OP_BEQ:            state_next = S_BEQ;
                    OP_JAL:            state_next = S_JAL;
                    default: begin
                        state_next = S_FETCH;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                state_next = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                AdrSrc     = 1'b1;
                state_next = ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                ResultSrc  = 2'b01;
                RegWrite   = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMWRITE: begin
                // Strobe stays up for the whole stall, including the
                // completing cycle.
                AdrSrc     = 1'b1;
                MemWrite   = 1'b1;
                state_next = ready ? S_FETCH : S_MEMWRITE;
            end
            S_EXECR: begin
                ALUSrcA    = 2'b10;
                ALUOp      = 2'b10;
                state_next = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUOp      = 2'b10;
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite   = 1'b1;
                state_next = S_FETCH;
            end
            S_BEQ: begin
                // ALUOut already holds the target; take it only if rs1 == rs2.
                ALUSrcA    = 2'b10;
                ALUOp      = 2'b01;
                PCWrite    = zero;
                state_next = S_FETCH;
            end
            S_JAL: begin
                // Target from ALUOut into PC while old PC + 4 is formed for rd.
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b10;
                PCWrite    = 1'b1;
                state_next = S_ALUWB;
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase

        // The register already sits in FETCH during reset; keep every
        // enable quiet until reset is released.
        if (!rst_n) begin
            PCWrite    = 1'b0;
            IRWrite    = 1'b0;
            MemWrite   = 1'b0;
            RegWrite   = 1'b0;
            illegal_op = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// ----------------------------------------------------------------------------
// tb_multicycle_controller
//
// Self-checking bench for multicycle_controller: a directed vector table of
// instruction sequences, hand-written reset / no-wait sequences, and a random
// instruction stream checked against an instruction-level reference model.
// ----------------------------------------------------------------------------
module tb_multicycle_controller;

    localparam logic [6:0] LW   = 7'b0000011;
    localparam logic [6:0] SW   = 7'b0100011;
    localparam logic [6:0] RT   = 7'b0110011;
    localparam logic [6:0] IT   = 7'b0010011;
    localparam logic [6:0] BQ   = 7'b1100011;
    localparam logic [6:0] JL   = 7'b1101111;
    localparam logic [6:0] BAD  = 7'b1111111;

    // enables = {PCWrite, IRWrite, MemWrite, RegWrite, illegal_op}
    localparam logic [4:0] E0   = 5'b00000;
    localparam logic [4:0] EPI  = 5'b11000;
    localparam logic [4:0] EPC  = 5'b10000;
    localparam logic [4:0] EMW  = 5'b00100;
    localparam logic [4:0] ERW  = 5'b00010;
    localparam logic [4:0] EIL  = 5'b00001;

    typedef struct packed {
        logic       pcw;
        logic       adr;
        logic       mw;
        logic       irw;
        logic [1:0] rs;
        logic [1:0] sa;
        logic [1:0] sb;
        logic       rw;
        logic [1:0] aluop;
        logic       ill;
    } outs_t;

    typedef struct {
        logic [6:0] op;
        logic       zero;
        logic       mr;
        int         st;
        logic [4:0] en;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic [6:0] op;
    logic       zero;
    logic       mem_ready;

    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal_op;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
    logic [3:0] state;

    logic       PCWrite_nw, AdrSrc_nw, MemWrite_nw, IRWrite_nw, RegWrite_nw, illegal_op_nw;
    logic [1:0] ResultSrc_nw, ALUSrcA_nw, ALUSrcB_nw, ALUOp_nw;
    logic [3:0] state_nw;

    outs_t act;
    outs_t act_nw;

    int errors = 0;
    int checks = 0;

    vec_t vecs[$];
    int   path[$];

    multicycle_controller #(.MEM_WAIT_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .RegWrite(RegWrite), .ALUOp(ALUOp), .illegal_op(illegal_op), .state(state)
    );

    multicycle_controller #(.MEM_WAIT_EN(1'b0)) dut_nw (
        .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
        .PCWrite(PCWrite_nw), .AdrSrc(AdrSrc_nw), .MemWrite(MemWrite_nw),
        .IRWrite(IRWrite_nw), .ResultSrc(ResultSrc_nw), .ALUSrcA(ALUSrcA_nw),
        .ALUSrcB(ALUSrcB_nw), .RegWrite(RegWrite_nw), .ALUOp(ALUOp_nw),
        .illegal_op(illegal_op_nw), .state(state_nw)
    );

    assign act    = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                     RegWrite, ALUOp, illegal_op};
    assign act_nw = {PCWrite_nw, AdrSrc_nw, MemWrite_nw, IRWrite_nw, ResultSrc_nw,
                     ALUSrcA_nw, ALUSrcB_nw, RegWrite_nw, ALUOp_nw, illegal_op_nw};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic is_legal(input logic [6:0] o);
        return (o == LW) || (o == SW) || (o == RT) || (o == IT) || (o == BQ) || (o == JL);
    endfunction

    // Expected outputs for a given state, read from the per-state control table.
    function automatic outs_t ref_out(input int st, input logic z, input logic mr,
                                      input logic [6:0] o);
        outs_t r;
        r = '0;
        case (st)
            0:  begin r.sb = 2'b10; r.rs = 2'b10; r.pcw = mr; r.irw = mr; end
            1:  begin r.sa = 2'b01; r.sb = 2'b01; r.ill = !is_legal(o); end
            2:  begin r.sa = 2'b10; r.sb = 2'b01; end
            3:  begin r.adr = 1'b1; end
            4:  begin r.rs = 2'b01; r.rw = 1'b1; end
            5:  begin r.adr = 1'b1; r.mw = 1'b1; end
            6:  begin r.sa = 2'b10; r.aluop = 2'b10; end
            7:  begin r.sa = 2'b10; r.sb = 2'b01; r.aluop = 2'b10; end
            8:  begin r.rw = 1'b1; end
            9:  begin r.sa = 2'b10; r.aluop = 2'b01; r.pcw = z; end
            10: begin r.sa = 2'b01; r.sb = 2'b10; r.pcw = 1'b1; end
            default: r = '0;
        endcase
        return r;
    endfunction

    // Reset view: FETCH muxes, every enable quiet.
    function automatic outs_t ref_rst(input logic z, input logic mr, input logic [6:0] o);
        outs_t r;
        r = ref_out(0, z, mr, o);
        r.pcw = 1'b0;
        r.irw = 1'b0;
        return r;
    endfunction

    task automatic check(input string name, input int exp_st, input logic [3:0] got_st,
                         input outs_t exp_o, input outs_t got_o);
        checks++;
        if (got_st !== 4'(exp_st) || got_o !== exp_o) begin
            errors++;
            $display("FAIL %s: got state=%0d outs=%h, required state=%0d outs=%h",
                     name, got_st, got_o, exp_st, exp_o);
        end
    endtask

    task automatic check_en(input string name, input logic [4:0] exp_en);
        logic [4:0] got;
        got = {PCWrite, IRWrite, MemWrite, RegWrite, illegal_op};
        checks++;
        if (got !== exp_en) begin
            errors++;
            $display("FAIL %s: got enables=%b, required %b", name, got, exp_en);
        end
    endtask

    task automatic add(input logic [6:0] o, input logic z, input logic mr, input int st,
                       input logic [4:0] en);
        vec_t v;
        v.op = o; v.zero = z; v.mr = mr; v.st = st; v.en = en;
        vecs.push_back(v);
    endtask

    // Instruction-level view: the states visited after FETCH for each opcode.
    task automatic build_path(input logic [6:0] o);
        path.delete();
        case (o)
            LW:      path = '{1, 2, 3, 4, 0};
            SW:      path = '{1, 2, 5, 0};
            RT:      path = '{1, 6, 8, 0};
            IT:      path = '{1, 7, 8, 0};
            BQ:      path = '{1, 9, 0};
            JL:      path = '{1, 10, 8, 0};
            default: path = '{1, 0};
        endcase
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        op        = LW;
        zero      = 1'b1;
        #1;
        check("reset_hold", 0, state, ref_rst(zero, mem_ready, op), act);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int exp_st;
        int nw_seq[6];
        logic [6:0] legal_ops[7];

        rst_n = 1'b0; op = LW; zero = 1'b0; mem_ready = 1'b1;
        legal_ops = '{LW, SW, RT, IT, BQ, JL, BAD};

        // ---------------- directed vector table ----------------
        add(LW, 0, 1, 0, EPI); add(LW, 0, 1, 1, E0); add(LW, 0, 1, 2, E0);
        add(LW, 0, 0, 3, E0);  add(LW, 0, 1, 3, E0); add(LW, 0, 1, 4, ERW);
        add(SW, 0, 1, 0, EPI); add(SW, 0, 1, 1, E0); add(SW, 0, 1, 2, E0);
        add(SW, 0, 0, 5, EMW); add(SW, 0, 0, 5, EMW); add(SW, 0, 0, 5, EMW);
        add(SW, 0, 1, 5, EMW);
        add(RT, 0, 0, 0, E0);  add(RT, 0, 1, 0, EPI); add(RT, 0, 1, 1, E0);
        add(RT, 0, 1, 6, E0);  add(RT, 0, 1, 8, ERW);
        add(IT, 0, 1, 0, EPI); add(IT, 0, 1, 1, E0); add(IT, 0, 1, 7, E0);
        add(IT, 0, 1, 8, ERW);
        add(BQ, 1, 1, 0, EPI); add(BQ, 1, 1, 1, E0); add(BQ, 1, 1, 9, EPC);
        add(BQ, 0, 1, 0, EPI); add(BQ, 0, 1, 1, E0); add(BQ, 0, 1, 9, E0);
        add(BAD, 0, 1, 0, EPI); add(BAD, 0, 1, 1, EIL);
        add(JL, 0, 1, 0, EPI); add(JL, 0, 1, 1, E0); add(JL, 0, 1, 10, EPC);
        add(JL, 0, 1, 8, ERW);
        add(LW, 0, 1, 0, EPI);

        apply_reset();
        foreach (vecs[i]) begin
            op = vecs[i].op; zero = vecs[i].zero; mem_ready = vecs[i].mr;
            #1;
            check($sformatf("vec%0d", i), vecs[i].st, state,
                  ref_out(vecs[i].st, zero, mem_ready, op), act);
            check_en($sformatf("vec%0d_en", i), vecs[i].en);
            @(negedge clk);
        end

        // ---------------- async reset in the middle of a MEMWRITE stall ----------------
        // Last table row left the DUT in DECODE with op=LW; steer it to a stalled store.
        op = SW; mem_ready = 1'b0;
        @(negedge clk);                     // MEMADR
        @(negedge clk);                     // MEMWRITE
        @(negedge clk);                     // still MEMWRITE
        #1;
        check("sw_stall_before_rst", 5, state, ref_out(5, zero, mem_ready, op), act);
        @(posedge clk);
        #2;
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        #1;
        check("async_rst_mid_write", 0, state, ref_rst(zero, mem_ready, op), act);
        @(negedge clk);
        rst_n     = 1'b1;

        // ---------------- first cycles after release: stalled FETCH vs no-wait build ----------------
        op = LW; mem_ready = 1'b0;
        nw_seq = '{0, 1, 2, 3, 4, 0};
        for (int k = 0; k < 6; k++) begin
            #1;
            check($sformatf("nowait_lw%0d", k), nw_seq[k], state_nw,
                  ref_out(nw_seq[k], zero, 1'b1, op), act_nw);
            check($sformatf("fetch_stall%0d", k), 0, state,
                  ref_out(0, zero, mem_ready, op), act);
            @(negedge clk);
        end
        mem_ready = 1'b1;
        #1;
        check("fetch_release", 0, state, ref_out(0, zero, mem_ready, op), act);
        @(negedge clk);
        #1;
        check("after_release_decode", 1, state, ref_out(1, zero, mem_ready, op), act);

        // ---------------- random instruction stream vs reference model ----------------
        apply_reset();
        exp_st = 0;
        for (int c = 0; c < 1500; c++) begin
            if (exp_st == 0) begin
                if ($urandom_range(0, 7) == 0) op = 7'($urandom);
                else op = legal_ops[$urandom_range(0, 6)];
            end
            zero      = 1'($urandom);
            mem_ready = ($urandom_range(0, 3) != 0);
            #1;
            check($sformatf("rand%0d", c), exp_st, state,
                  ref_out(exp_st, zero, mem_ready, op), act);
            if ((exp_st == 0 || exp_st == 3 || exp_st == 5) && !mem_ready) begin
                exp_st = exp_st;
            end else begin
                if (exp_st == 0) build_path(op);
                exp_st = path.pop_front();
            end
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
